// File: rtl/key_event_pkg.sv
// ==== key_event_pkg: default sizes and event record for the key event queue. Rev 1.0 ====
`default_nettype none

package key_event_pkg;

   localparam int LANES_DEF    = 4;
   localparam int TS_W_DEF     = 16;
   localparam int DEPTH_DEF    = 8;
   localparam int TICK_DIV_DEF = 50_000;

   // Lane index width; a single-lane build still needs one bit to carry a field.
   function automatic int lane_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   localparam int LANE_W_DEF = lane_w(LANES_DEF);

   typedef struct packed {
      logic [LANE_W_DEF-1:0] lane;
      logic                  press;
      logic [TS_W_DEF-1:0]   stamp;
   } key_event_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ==== sync_fifo: first-word-fall-through FIFO with count-based full/empty. Rev 1.0 ====
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/key_event_queue.sv
// ==== key_event_queue: timestamped key press/release events behind a valid/ready FIFO. ====
// ==== Release events are queued only when KEY_EVENT_RELEASE_EN is defined. Rev 1.0      ====
`default_nettype none

module key_event_queue
   import key_event_pkg::*;
#(
   parameter int  LANES    = LANES_DEF,
   parameter int  DEPTH    = DEPTH_DEF,
   parameter int  TS_W     = TS_W_DEF,
   parameter int  TICK_DIV = TICK_DIV_DEF,
   localparam int LW       = lane_w(LANES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LANES-1:0] keys_in,
   input  logic             time_clr,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [LW-1:0]    ev_lane,
   output logic             ev_press,
   output logic [TS_W-1:0]  ev_time,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int PW = $clog2(TICK_DIV);
`ifdef KEY_EVENT_RELEASE_EN
   localparam int EW = LW + 1 + TS_W;
`else
   localparam int EW = LW + TS_W;
`endif

   logic [PW-1:0]    presc;
   logic [TS_W-1:0]  ts;
   logic             armed;
   logic [LANES-1:0] prev;
   logic [LANES-1:0] edges;
   logic [LANES-1:0] pending;
   logic [TS_W-1:0]  pend_ts [LANES];
   logic [LANES-1:0] issue_mask;
   logic [LW-1:0]    sel;
   logic             any_pend;
   logic             issue;
   logic             pop;
   logic             empty;
   logic             full;
   logic             ovf_set;
   logic [EW-1:0]    push_data;
   logic [EW-1:0]    head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         ts    <= '0;
      end else if (time_clr) begin
         presc <= '0;
         ts    <= '0;
      end else if (presc == PW'(TICK_DIV - 1)) begin
         presc <= '0;
         ts    <= ts + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

`ifdef KEY_EVENT_RELEASE_EN
   logic [LANES-1:0] pend_dir;
   assign edges     = armed ? (keys_in ^ prev) : '0;
   assign push_data = {sel, pend_dir[sel], pend_ts[sel]};
   assign ev_press  = ev_valid ? head[TS_W] : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_dir <= '0;
      else        pend_dir <= (pend_dir & ~edges) | (keys_in & edges);
   end
`else
   assign edges     = armed ? (keys_in & ~prev) : '0;
   assign push_data = {sel, pend_ts[sel]};
   assign ev_press  = 1'b1;
`endif

   // Fixed priority: the lowest-index pending lane wins the single FIFO slot.
   always_comb begin
      sel      = '0;
      any_pend = 1'b0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel      = LW'(i);
            any_pend = 1'b1;
         end
      end
   end

   assign pop        = ev_valid && ev_ready;
   assign issue      = any_pend && (!full || pop);
   assign issue_mask = issue ? (LANES'(1) << sel) : '0;
   // Lane being issued this cycle frees its slot, so a fresh edge there is no loss.
   assign ovf_set    = |(edges & pending & ~issue_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed    <= 1'b0;
         prev     <= '0;
         pending  <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < LANES; i++) pend_ts[i] <= '0;
      end else begin
         armed    <= 1'b1;
         prev     <= keys_in;
         pending  <= (pending & ~issue_mask) | edges;
         overflow <= ovf_set | (overflow & ~ovf_clr);
         for (int i = 0; i < LANES; i++) begin
            if (edges[i]) pend_ts[i] <= ts;
         end
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (issue),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .empty     (empty),
      .full      (full)
   );

   assign ev_valid = !empty;
   assign ev_lane  = ev_valid ? head[EW-1 -: LW] : '0;
   assign ev_time  = ev_valid ? head[TS_W-1:0]   : '0;

endmodule

`default_nettype wire

// File: tb/tb_key_event_queue.sv
// ==== tb_key_event_queue: directed and random checks against a queue-based event model. ====
`default_nettype none

module tb_key_event_queue;

   localparam int LANES    = 4;
   localparam int DEPTH    = 8;
   localparam int TS_W     = 6;
   localparam int TICK_DIV = 3;
`ifdef KEY_EVENT_RELEASE_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] keys_in;
   logic       time_clr;
   logic       ev_valid;
   logic       ev_ready;
   logic [1:0] ev_lane;
   logic       ev_press;
   logic [5:0] ev_time;
   logic       overflow;
   logic       ovf_clr;

   always #5 clk = ~clk;

   key_event_queue #(
      .LANES    (LANES),
      .DEPTH    (DEPTH),
      .TS_W     (TS_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .keys_in  (keys_in),
      .time_clr (time_clr),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_lane  (ev_lane),
      .ev_press (ev_press),
      .ev_time  (ev_time),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   typedef struct {
      int lane;
      int press;
      int stamp;
   } ev_t;

   int checks   = 0;
   int failures = 0;

   // Reference state: one pending slot per lane, the FIFO as a queue, ms counter.
   bit [3:0] m_prev, m_pend, m_dir;
   int       m_pts [4];
   bit       m_armed, m_ovf;
   int       m_presc, m_ts;
   ev_t      m_q [$];
   ev_t      obs [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = '0; m_pend = '0; m_dir = '0; m_armed = 0; m_ovf = 0;
      m_presc = 0; m_ts = 0;
      for (int i = 0; i < 4; i++) m_pts[i] = 0;
      m_q.delete();
   endtask

   task automatic model_step();
      bit       pop, issue, ovf_set;
      int       sel;
      bit [3:0] edg;
      ev_t      e;
      pop = (m_q.size() > 0) && ev_ready;
      sel = -1;
      for (int i = 0; i < 4; i++) if (m_pend[i] && sel < 0) sel = i;
      issue = (sel >= 0) && ((m_q.size() < DEPTH) || pop);
      edg = m_armed ? (keys_in ^ m_prev) : 4'b0000;
      if (!REL) edg = edg & keys_in;
      if (pop) void'(m_q.pop_front());
      if (issue) begin
         e.lane = sel; e.press = m_dir[sel]; e.stamp = m_pts[sel];
         m_q.push_back(e);
         m_pend[sel] = 1'b0;
      end
      ovf_set = 0;
      for (int i = 0; i < 4; i++) begin
         if (edg[i]) begin
            if (m_pend[i]) ovf_set = 1;
            m_pend[i] = 1'b1;
            m_dir[i]  = keys_in[i];
            m_pts[i]  = m_ts;
         end
      end
      m_ovf = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      if (time_clr) begin
         m_presc = 0; m_ts = 0;
      end else if (m_presc == TICK_DIV - 1) begin
         m_presc = 0; m_ts = (m_ts + 1) % (1 << TS_W);
      end else begin
         m_presc++;
      end
      m_prev = keys_in;
      m_armed = 1;
   endtask

   // Inputs are set before the call; outputs compared on the following falling edge.
   task automatic step();
      ev_t o;
      if (ev_valid && ev_ready) begin
         o.lane = ev_lane; o.press = ev_press; o.stamp = ev_time;
         obs.push_back(o);
      end
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_eq("valid", ev_valid, m_q.size() > 0);
      check_eq("overflow", overflow, m_ovf);
      if (!REL) check_eq("press_const", ev_press, 1);
      if (m_q.size() > 0) begin
         check_eq("lane", ev_lane, m_q[0].lane);
         check_eq("press", ev_press, m_q[0].press);
         check_eq("time", ev_time, m_q[0].stamp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_valid", ev_valid, 0);
      check_eq("rst_lane", ev_lane, 0);
      check_eq("rst_time", ev_time, 0);
      check_eq("rst_ovf", overflow, 0);
      if (REL) check_eq("rst_press", ev_press, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; keys_in = 4'b0010; time_clr = 0; ev_ready = 1; ovf_clr = 0;
      model_reset();

      // Key held through reset: no press, one release on lane 1 if releases enabled.
      do_reset();
      obs.delete();
      repeat (100) step();
      keys_in = 4'b0000;
      repeat (8) step();
      check_eq("held_count", obs.size(), REL ? 1 : 0);
      if (REL && obs.size() > 0) begin
         check_eq("held_lane", obs[0].lane, 1);
         check_eq("held_press", obs[0].press, 0);
      end

      // Latency and timestamp after a song-start clear.
      time_clr = 1; step(); time_clr = 0;
      repeat (9) step();
      keys_in = 4'b0100; step();
      check_eq("lat_e0", ev_valid, 0);
      step();
      check_eq("lat_e1", ev_valid, 1);
      check_eq("lat_lane", ev_lane, 2);
      check_eq("lat_time", ev_time, 9 / TICK_DIV);
      keys_in = 4'b0000;
      repeat (10) step();

      // All lanes at once: ascending lanes on consecutive cycles.
      keys_in = 4'b1111; step(); step();
      for (int i = 0; i < 4; i++) begin
         check_eq("simul_valid", ev_valid, 1);
         check_eq("simul_lane", ev_lane, i);
         step();
      end
      keys_in = 4'b0000;
      repeat (10) step();

      // FIFO fills, ninth edge waits, tenth overwrites pending.
      ev_ready = 0;
      for (int k = 0; k < 10; k++) begin
         keys_in[0] = ~keys_in[0];
         repeat (20) step();
      end
      check_eq("full_ovf", overflow, REL ? 1 : 0);
      obs.delete();
      ev_ready = 1;
      repeat (30) step();
      check_eq("drain_count", obs.size(), REL ? 9 : 5);
      ovf_clr = 1; step(); ovf_clr = 0;
      check_eq("ovf_cleared", overflow, 0);

      // Random traffic, including timestamp wrap and a mid-run reset.
      for (int c = 0; c < 3000; c++) begin
         if (c == 1400) do_reset();
         if (c % 100 == 0) n = $urandom_range(0, 3);
         for (int l = 0; l < 4; l++) if ($urandom_range(0, 7) == 0) keys_in[l] = ~keys_in[l];
         ev_ready = ($urandom_range(0, 3) < n);
         time_clr = ($urandom_range(0, 299) == 0);
         ovf_clr  = ($urandom_range(0, 49) == 0);
         step();
      end
      time_clr = 0; ovf_clr = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/key_event_queue.md
# key_event_queue

Converts the debounced lane-key levels (F1–F4) into a timestamped stream of press/release events and buffers them in a small FIFO behind a valid/ready handshake. Sits between the key debouncer and the judge/scoring logic, so hit judgement uses the millisecond the key actually changed rather than the cycle the judge gets round to reading it.

## Interface
- LANES, 4, number of key lanes
- DEPTH, 8, event FIFO depth; power of two, ≥2
- TS_W, 16, timestamp width in ticks
- TICK_DIV, 50_000, clk cycles per timestamp tick (1 ms at 50 MHz); ≥2
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- keys_in  in  LANES  debounced key levels, 1 = pressed, synchronous to clk
- time_clr  in  1  synchronous clear of prescaler and timestamp (song start)
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head this cycle
- ev_lane  out  clog2(LANES)  lane index of head event
- ev_press  out  1  1 = press, 0 = release
- ev_time  out  TS_W  tick count at which the edge was sampled
- overflow  out  1  sticky: an event was lost
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- Timebase: prescaler counts 0..TICK_DIV-1; on wrap, ts increments modulo 2^TS_W (wrap-around silent, no flag). time_clr sets both to 0 that edge; has priority over increment.
- Arming: armed resets to 0. First edge after reset loads prev <= keys_in, sets armed, generates no events (a key held through reset produces no spurious press).
- Edge detect (armed): edge = keys_in ^ prev; prev <= keys_in every cycle. Each edge lane sets pending[lane], pend_dir[lane] = keys_in[lane], pend_ts[lane] = current ts.
- Re-edge on a lane whose pending is still set: entry overwritten with the newer edge, overflow set.
- Issue: each cycle, lowest-index pending lane is written to FIFO if FIFO not full, or full with a pop in the same cycle. Its pending bit clears that edge; one event per cycle max. A new edge on the lane being issued in the same cycle re-sets pending (not overflow).
- FIFO: first-word-fall-through; ev_valid = not empty; pop on ev_valid && ev_ready. ev_ready while empty is ignored. Outputs hold stable while ev_valid && !ev_ready.
- Full: events wait in pending, never dropped from pending except by the overwrite rule.
- ovf_clr clears overflow; a same-cycle overflow set wins.

## Timing
- Reset values: ev_valid 0, ev_lane 0, ev_press 0, ev_time 0, overflow 0; FIFO empty, pending 0, prev 0, ts 0, prescaler 0, armed 0.
- Latency: keys_in changes before edge E0 → pending at E0 → FIFO write at E1 → ev_valid high after E1 (2 cycles, empty FIFO, no contention).
- k simultaneous edges issue over k consecutive cycles, lane order ascending, all carrying the same ev_time.
- Throughput: 1 event/cycle in and out; simultaneous push and pop at full keeps count at DEPTH.
- Reset mid-operation: all state and queued events discarded, re-arm required.

## Configuration
- KEY_EVENT_RELEASE_EN defined: press and release edges both queued as above.
- Undefined: only rising edges (0→1) set pending; falling edges ignored and never cause overflow; ev_press is constant 1.

## Structure
- Package key_event_pkg: LANES, TS_W defaults, key_event_t struct {lane, press, time}, TICK_DIV default.
- Sub-module sync_fifo (parameterised width/depth, FWFT, count-based full/empty) holds key_event_t entries; edge detect, pending, arbitration and timebase stay in key_event_queue.

## Test plan
- Reset with keys_in=4'b0010 held, release after 100 cycles, ev_ready=1 → no press event; one release {lane 1, press 0}.
- TICK_DIV=4, time_clr then lane 2 press at cycle 10 → event {2, 1, ts=2}, ev_valid 2 cycles after the edge.
- keys_in 0000→1111 in one cycle, ev_ready=1 → four events lanes 0,1,2,3 on consecutive cycles, identical ev_time.
- DEPTH=8, ev_ready=0, 9 press/release edges on lane 0 spaced 20 cycles → 8 queued, 9th waits in pending; 10th edge sets overflow; ev_ready=1 drains 9 in order; ovf_clr clears overflow.
- TS_W=4, TICK_DIV=2, run 40 cycles then press → ev_time = (40/2) mod 16 = 4.
- KEY_EVENT_RELEASE_EN undefined: press/release lane 3 ×3 → exactly 3 events, all ev_press=1.
